resnet_stream_sequencer: RTL and testbench
==========================================

Name: resnet_stream_sequencer

Overview:
- Host-side controller that runs one resnet accelerator invocation.
- Pulses the accelerator's flush, then serves its input and kernel stencil read streams from two memories. Each stream is first-word-fall-through with a per-element address generator.
- Writes every valid output word to an output memory and reports done, error and the output count.
- Replaces free-running testbench stimulus with a deterministic, bounded, checkable sequence.

Parameters:
- DATA_W, 16, stream and memory data width
- ADDR_W, 16, memory address width
- IN_COUNT, 4096, input elements per invocation (>=1)
- KER_COUNT, 576, kernel elements per invocation (>=1)
- OUT_COUNT, 1024, output elements expected (>=1)
- FLUSH_CYCLES, 1, cycles dut_flush is held high (>=1)
- TIMEOUT_W, 20, width of the output watchdog counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  launch; sampled only in IDLE or DONE
- in_base, ker_base, out_base  in  ADDR_W  base addresses; latched on accepted start
- in_mem_ren, ker_mem_ren  out  1  memory read strobes
- in_mem_addr, ker_mem_addr  out  ADDR_W  read addresses
- in_mem_rdata, ker_mem_rdata  in  DATA_W  read data; 1-cycle latency, held while ren=0
- out_mem_wen  out  1  output write strobe
- out_mem_addr  out  ADDR_W  output write address
- out_mem_wdata  out  DATA_W  output write data
- dut_flush  out  1  accelerator flush
- dut_in_read_en, dut_ker_read_en  in  1  accelerator consumes the current word
- dut_in_data, dut_ker_data  out  DATA_W  current word; passthrough of mem rdata
- dut_out_valid  in  1  output word valid
- dut_out_data  in  DATA_W  output word
- busy  out  1  state is PREFETCH, FLUSH or RUN
- done  out  1  high while in DONE
- error  out  1  sticky error; cleared on accepted start or rst
- out_count  out  ADDR_W  outputs written this invocation

Behaviour:
- Reset: state IDLE. All indices, watchdog and error are 0. Every strobe and dut_flush is 0; busy=0, done=0, out_count=0. Reset mid-operation aborts immediately with no further memory traffic.
- States:
  - IDLE -> PREFETCH on start.
  - PREFETCH: 1 cycle; in_mem_ren=ker_mem_ren=1 at the base addresses. Then -> FLUSH.
  - FLUSH: dut_flush=1 for exactly FLUSH_CYCLES cycles. Then -> RUN.
  - RUN -> DONE on the cycle the OUT_COUNT-th output is written.
  - RUN -> ERR when the watchdog saturates at all-ones.
  - DONE -> PREFETCH on start.
  - ERR: error=1; -> PREFETCH on start.
- Stream service, identical for input (limit IN_COUNT) and kernel (limit KER_COUNT):
  - Active in FLUSH and RUN, with idx < limit, on read_en: idx increments the same cycle.
  - If idx+1 < limit, ren=1 with addr = base+idx+1, issued combinationally that cycle. The next word appears on dut_*_data the following cycle.
  - Back-to-back read_en is sustained at 1 word per cycle.
  - On the last element, no read is issued and data holds the last word.
  - read_en with idx == limit, or read_en outside FLUSH/RUN: sets error. No read, idx unchanged.
- Output path:
  - In RUN, on dut_out_valid: out_mem_wen=1 combinationally, with addr = out_base+out_idx and wdata = dut_out_data. out_idx increments.
  - dut_out_valid outside RUN: sets error, no write.
- Watchdog:
  - Clears on entering RUN and on every dut_out_valid.
  - Otherwise increments each RUN cycle.
- Address arithmetic: base+index in ADDR_W bits, wrapping modulo 2^ADDR_W.
- start while busy is ignored.
- Input and kernel reads may occur in the same cycle as an output write; all are independent.

Decomposition:
- Package resnet_seq_pkg: state enum (IDLE, PREFETCH, FLUSH, RUN, DONE, ERR) and a localparam for watchdog all-ones.
- Sub-module stream_addr_gen, instanced twice (input, kernel):
  - Parameters: limit, ADDR_W.
  - Ports: clk, rst, base, prefetch, active, read_en → ren, addr, overrun.

Test Plan:
- Params IN=4, KER=2, OUT=3, FLUSH_CYCLES=2. Start at in_base=0x10, ker_base=0x20, out_base=0x30 -> busy next cycle; PREFETCH reads 0x10 and 0x20; dut_flush high exactly 2 cycles.
- In RUN, drive in read_en 4 consecutive cycles -> reads at 0x11, 0x12, 0x13 only. dut_in_data steps memory words 0..3 one per cycle, then holds word 3.
- Outputs 0xA, 0xB, 0xC with gaps -> writes at 0x30, 0x31, 0x32; done the cycle after the third write; out_count=3; error=0.
- Fifth input read_en, or kernel read_en after 2 elements -> error=1 sticky, no extra ren; next start clears error.
- TIMEOUT_W=4 with no output for 15 RUN cycles -> ERR; error=1; busy=0.
- rst asserted mid-RUN after 1 output -> next cycle all outputs at reset values. A fresh start re-reads from the base addresses.

Source files
------------

// File: rtl/resnet_seq_pkg.sv
// Shared definitions for the resnet stream sequencer.
//   seq_state_t  : sequencer state encoding
//   WD_ALL_ONES  : all-ones pattern; the top slices it to its watchdog width
package resnet_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFETCH = 3'd1,
        FLUSH    = 3'd2,
        RUN      = 3'd3,
        DONE     = 3'd4,
        ERR      = 3'd5
    } seq_state_t;

    localparam logic [31:0] WD_ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/stream_addr_gen.sv
// First-word-fall-through read stream address generator.
// The first word is fetched during prefetch. Each consumed word then triggers
// the read for the following word. That read is issued in the same cycle, so
// the stream sustains one word per cycle.
//   clk, rst  : clock, synchronous active-high reset
//   base      : stream base address
//   prefetch  : issue the read at base and rewind the index
//   active    : stream may be consumed (FLUSH or RUN)
//   read_en   : consumer takes the current word
//   ren, addr : memory read strobe and address
//   overrun   : read_en that could not be honoured (exhausted or inactive)
module stream_addr_gen #(
    parameter int LIMIT  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] base,
    input  logic              prefetch,
    input  logic              active,
    input  logic              read_en,
    output logic              ren,
    output logic [ADDR_W-1:0] addr,
    output logic              overrun
);
    localparam int IDX_W = $clog2(LIMIT + 1);
    localparam logic [IDX_W-1:0] LIMIT_I    = IDX_W'(LIMIT);
    localparam logic [IDX_W-1:0] LIMIT_M1_I = IDX_W'(LIMIT - 1);

    logic [IDX_W-1:0] idx_r;
    logic             consume_s;

    // Read strobe, read address and overrun decode
    always_comb begin
        consume_s = active && read_en && (idx_r < LIMIT_I);
        overrun   = 1'b0;
        ren       = 1'b0;
        addr      = base;
        if (rst) begin
            // Reset aborts immediately: no memory traffic in the reset cycle.
            consume_s = 1'b0;
        end else if (prefetch) begin
            ren  = 1'b1;
            addr = base;
        end else if (consume_s && (idx_r < LIMIT_M1_I)) begin
            // Fetch the next word. Nothing is fetched after the last element,
            // so the memory keeps presenting the last word.
            ren  = 1'b1;
            addr = base + ADDR_W'(idx_r) + ADDR_W'(1'b1);
        end else begin
            ren  = 1'b0;
        end
        if (!rst) begin
            overrun = read_en && !consume_s;
        end else begin
            overrun = 1'b0;
        end
    end

    // Element index: rewound on prefetch, advanced on each consumed word
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= '0;
        end else if (prefetch) begin
            idx_r <= '0;
        end else if (consume_s) begin
            idx_r <= idx_r + IDX_W'(1'b1);
        end else begin
            idx_r <= idx_r;
        end
    end

endmodule

// File: rtl/resnet_stream_sequencer.sv
// Host-side controller for one resnet accelerator invocation.
// The sequence is: prefetch the first input and kernel words, pulse
// dut_flush, serve both read streams, and write every output word.
// A watchdog moves the sequencer to ERR if the outputs stall.
//   start, *_base              : launch and base addresses (latched on start)
//   in_mem_*, ker_mem_*        : stream memory read ports (1-cycle latency)
//   out_mem_*                  : output memory write port
//   dut_*                      : accelerator-side stream and output handshakes
//   busy, done, error, out_count : status
module resnet_stream_sequencer
    import resnet_seq_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int IN_COUNT     = 4096,
    parameter int KER_COUNT    = 576,
    parameter int OUT_COUNT    = 1024,
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] ker_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              in_mem_ren,
    output logic [ADDR_W-1:0] in_mem_addr,
    input  logic [DATA_W-1:0] in_mem_rdata,
    output logic              ker_mem_ren,
    output logic [ADDR_W-1:0] ker_mem_addr,
    input  logic [DATA_W-1:0] ker_mem_rdata,
    output logic              out_mem_wen,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic [DATA_W-1:0] out_mem_wdata,
    output logic              dut_flush,
    input  logic              dut_in_read_en,
    input  logic              dut_ker_read_en,
    output logic [DATA_W-1:0] dut_in_data,
    output logic [DATA_W-1:0] dut_ker_data,
    input  logic              dut_out_valid,
    input  logic [DATA_W-1:0] dut_out_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] out_count
);
    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0]      FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W-1:0]    OUT_LAST   = ADDR_W'(OUT_COUNT - 1);
    localparam logic [TIMEOUT_W-1:0] WD_MAX     = WD_ALL_ONES[TIMEOUT_W-1:0];
    localparam logic [TIMEOUT_W-1:0] WD_MAX_M1  = WD_MAX - TIMEOUT_W'(1'b1);

    seq_state_t          state_r;
    logic [ADDR_W-1:0]   in_base_r;
    logic [ADDR_W-1:0]   ker_base_r;
    logic [ADDR_W-1:0]   out_base_r;
    logic [ADDR_W-1:0]   out_idx_r;
    logic [TIMEOUT_W-1:0] wd_r;
    logic [FC_W-1:0]     flush_cnt_r;
    logic                error_r;

    logic start_ok_s;
    logic prefetch_s;
    logic active_s;
    logic write_s;
    logic bad_valid_s;
    logic wd_trip_s;
    logic in_ovr_s;
    logic ker_ovr_s;

    stream_addr_gen #(.LIMIT(IN_COUNT), .ADDR_W(ADDR_W)) u_in_gen (
        .clk      (clk),
        .rst      (rst),
        .base     (in_base_r),
        .prefetch (prefetch_s),
        .active   (active_s),
        .read_en  (dut_in_read_en),
        .ren      (in_mem_ren),
        .addr     (in_mem_addr),
        .overrun  (in_ovr_s)
    );

    stream_addr_gen #(.LIMIT(KER_COUNT), .ADDR_W(ADDR_W)) u_ker_gen (
        .clk      (clk),
        .rst      (rst),
        .base     (ker_base_r),
        .prefetch (prefetch_s),
        .active   (active_s),
        .read_en  (dut_ker_read_en),
        .ren      (ker_mem_ren),
        .addr     (ker_mem_addr),
        .overrun  (ker_ovr_s)
    );

    // State decode, output write path and status outputs
    always_comb begin
        start_ok_s  = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
        prefetch_s  = (state_r == PREFETCH);
        active_s    = (state_r == FLUSH) || (state_r == RUN);
        write_s     = (state_r == RUN) && dut_out_valid && !rst;
        bad_valid_s = (state_r != RUN) && dut_out_valid && !rst;
        wd_trip_s   = (state_r == RUN) && !dut_out_valid && (wd_r == WD_MAX_M1);

        out_mem_wen   = write_s;
        out_mem_addr  = out_base_r + out_idx_r;
        out_mem_wdata = dut_out_data;
        dut_in_data   = in_mem_rdata;
        dut_ker_data  = ker_mem_rdata;
        dut_flush     = (state_r == FLUSH);
        busy          = (state_r == PREFETCH) || (state_r == FLUSH) || (state_r == RUN);
        done          = (state_r == DONE);
        error         = error_r;
        out_count     = out_idx_r;
    end

    // Sequencer FSM, watchdog, output index and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_base_r   <= '0;
            ker_base_r  <= '0;
            out_base_r  <= '0;
            out_idx_r   <= '0;
            wd_r        <= '0;
            flush_cnt_r <= '0;
            error_r     <= 1'b0;
        end else begin
            // An accepted start clears the error. Any error event in the same
            // cycle still wins.
            error_r <= (error_r && !start_ok_s) || in_ovr_s || ker_ovr_s ||
                       bad_valid_s || wd_trip_s;
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (start_ok_s) begin
                        in_base_r  <= in_base;
                        ker_base_r <= ker_base;
                        out_base_r <= out_base;
                        out_idx_r  <= '0;
                        state_r    <= PREFETCH;
                    end else begin
                        state_r    <= state_r;
                    end
                end
                PREFETCH: begin
                    flush_cnt_r <= '0;
                    state_r     <= FLUSH;
                end
                FLUSH: begin
                    if (flush_cnt_r == FLUSH_LAST) begin
                        wd_r    <= '0;
                        state_r <= RUN;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + FC_W'(1'b1);
                    end
                end
                RUN: begin
                    if (write_s) begin
                        out_idx_r <= out_idx_r + ADDR_W'(1'b1);
                        wd_r      <= '0;
                        if (out_idx_r == OUT_LAST) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= RUN;
                        end
                    end else if (wd_trip_s) begin
                        wd_r    <= WD_MAX;
                        state_r <= ERR;
                    end else begin
                        wd_r    <= wd_r + TIMEOUT_W'(1'b1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resnet_stream_sequencer.sv
// Scoreboard bench for resnet_stream_sequencer (IN=4, KER=2, OUT=3,
// FLUSH_CYCLES=2, TIMEOUT_W=4). Expected memory reads and writes are queued
// by the stimulus. A negedge monitor pops and compares them whenever the DUT
// strobes a memory port. Status outputs are compared directly.
module tb_resnet_stream_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] in_base, ker_base, out_base;
    logic        in_mem_ren, ker_mem_ren, out_mem_wen;
    logic [15:0] in_mem_addr, ker_mem_addr, out_mem_addr, out_mem_wdata;
    logic [15:0] in_mem_rdata = 16'h0000;
    logic [15:0] ker_mem_rdata = 16'h0000;
    logic        dut_flush;
    logic        dut_in_read_en, dut_ker_read_en, dut_out_valid;
    logic [15:0] dut_in_data, dut_ker_data, dut_out_data;
    logic        busy, done, error;
    logic [15:0] out_count;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_in_q[$];
    logic [15:0] exp_ker_q[$];
    logic [31:0] exp_out_q[$];
    logic [15:0] exp_out_addr;

    always #5 clk = ~clk;

    resnet_stream_sequencer #(
        .DATA_W(16), .ADDR_W(16), .IN_COUNT(4), .KER_COUNT(2),
        .OUT_COUNT(3), .FLUSH_CYCLES(2), .TIMEOUT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_base(in_base), .ker_base(ker_base), .out_base(out_base),
        .in_mem_ren(in_mem_ren), .in_mem_addr(in_mem_addr), .in_mem_rdata(in_mem_rdata),
        .ker_mem_ren(ker_mem_ren), .ker_mem_addr(ker_mem_addr), .ker_mem_rdata(ker_mem_rdata),
        .out_mem_wen(out_mem_wen), .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
        .dut_flush(dut_flush),
        .dut_in_read_en(dut_in_read_en), .dut_ker_read_en(dut_ker_read_en),
        .dut_in_data(dut_in_data), .dut_ker_data(dut_ker_data),
        .dut_out_valid(dut_out_valid), .dut_out_data(dut_out_data),
        .busy(busy), .done(done), .error(error), .out_count(out_count)
    );

    // Memory model: word content is a tag plus its address, 1-cycle latency.
    always @(posedge clk) begin
        if (in_mem_ren)  in_mem_rdata  <= 16'h1000 + in_mem_addr;
        if (ker_mem_ren) ker_mem_rdata <= 16'h2000 + ker_mem_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got strobe with 0x%0h expected no strobe", name, act);
    endtask

    // Monitor: compare every memory strobe against the scoreboard queues.
    always @(negedge clk) begin
        if (in_mem_ren === 1'b1) begin
            if (exp_in_q.size() == 0) unexpected("in_read", 32'(in_mem_addr));
            else chk("in_read_addr", 32'(in_mem_addr), 32'(exp_in_q.pop_front()));
        end
        if (ker_mem_ren === 1'b1) begin
            if (exp_ker_q.size() == 0) unexpected("ker_read", 32'(ker_mem_addr));
            else chk("ker_read_addr", 32'(ker_mem_addr), 32'(exp_ker_q.pop_front()));
        end
        if (out_mem_wen === 1'b1) begin
            if (exp_out_q.size() == 0) unexpected("out_write", {out_mem_addr, out_mem_wdata});
            else chk("out_write", {out_mem_addr, out_mem_wdata}, exp_out_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_out(input logic [15:0] d);
        exp_out_q.push_back({exp_out_addr, d});
        exp_out_addr = exp_out_addr + 16'h0001;
        dut_out_valid = 1'b1;
        dut_out_data  = d;
        tick();
        dut_out_valid = 1'b0;
    endtask

    // Issue start, expect the prefetch reads, and advance to the first RUN cycle.
    task automatic launch_to_run(input string tag);
        start = 1'b1;
        exp_in_q.push_back(16'h0010);
        exp_ker_q.push_back(16'h0020);
        exp_out_addr = 16'h0030;
        tick();
        start = 1'b0;
        #1;
        chk({tag, "_busy_prefetch"}, 32'(busy), 32'd1);
        chk({tag, "_err_cleared"}, 32'(error), 32'd0);
        tick();
        tick();
        tick();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_out_count"}, 32'(out_count), 32'd0);
        chk({tag, "_flush"}, 32'(dut_flush), 32'd0);
        chk({tag, "_strobes"}, {29'd0, in_mem_ren, ker_mem_ren, out_mem_wen}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        in_base = 16'h0010; ker_base = 16'h0020; out_base = 16'h0030;
        dut_in_read_en = 1'b0; dut_ker_read_en = 1'b0;
        dut_out_valid = 1'b0; dut_out_data = 16'h0000;
        exp_out_addr = 16'h0030;
        tick();
        tick();
        #1;
        chk_reset_state("reset");
        rst = 1'b0;

        // Run 1: full invocation with explicit flush and stream checks.
        start = 1'b1;
        exp_in_q.push_back(16'h0010);
        exp_ker_q.push_back(16'h0020);
        tick();
        start = 1'b0;
        #1;
        chk("r1_busy_next", 32'(busy), 32'd1);
        chk("r1_flush_prefetch", 32'(dut_flush), 32'd0);
        tick(); #1;
        chk("r1_flush_1", 32'(dut_flush), 32'd1);
        chk("r1_in_first_word", 32'(dut_in_data), 32'h1010);
        chk("r1_ker_first_word", 32'(dut_ker_data), 32'h2020);
        tick(); #1;
        chk("r1_flush_2", 32'(dut_flush), 32'd1);
        tick(); #1;
        chk("r1_flush_off", 32'(dut_flush), 32'd0);
        chk("r1_busy_run", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            dut_in_read_en  = 1'b1;
            dut_ker_read_en = (i < 2);
            if (i < 3) exp_in_q.push_back(16'h0011 + 16'(i));
            if (i == 0) exp_ker_q.push_back(16'h0021);
            #1;
            chk("r1_in_word", 32'(dut_in_data), 32'h1010 + 32'(i));
            if (i < 2) chk("r1_ker_word", 32'(dut_ker_data), 32'h2020 + 32'(i));
            tick();
        end
        dut_in_read_en = 1'b0; dut_ker_read_en = 1'b0;
        #1;
        chk("r1_in_hold_last", 32'(dut_in_data), 32'h1013);
        chk("r1_ker_hold_last", 32'(dut_ker_data), 32'h2021);
        chk("r1_no_error", 32'(error), 32'd0);
        send_out(16'h000A);
        tick(); tick();
        send_out(16'h000B);
        tick(); #1;
        chk("r1_not_done_yet", 32'(done), 32'd0);
        chk("r1_count_2", 32'(out_count), 32'd2);
        send_out(16'h000C);
        #1;
        chk("r1_done", 32'(done), 32'd1);
        chk("r1_busy_off", 32'(busy), 32'd0);
        chk("r1_out_count", 32'(out_count), 32'd3);
        chk("r1_error_clean", 32'(error), 32'd0);
        // Output valid outside RUN: error, no write (monitor flags any write).
        dut_out_valid = 1'b1; dut_out_data = 16'h00EE;
        tick();
        dut_out_valid = 1'b0;
        #1;
        chk("stray_valid_error", 32'(error), 32'd1);

        // Run 2: input overrun, then reset mid-RUN after one output.
        launch_to_run("r2");
        for (int i = 0; i < 5; i++) begin
            dut_in_read_en = 1'b1;
            if (i < 3) exp_in_q.push_back(16'h0011 + 16'(i));
            if (i == 4) begin
                #1;
                chk("r2_no_error_before_overrun", 32'(error), 32'd0);
            end
            tick();
        end
        dut_in_read_en = 1'b0;
        #1;
        chk("r2_in_overrun_error", 32'(error), 32'd1);
        send_out(16'h000D);
        #1;
        chk("r2_sticky_error", 32'(error), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_reset_state("midrun_reset");

        // Run 3: kernel overrun, then watchdog expiry with no outputs.
        launch_to_run("r3");
        exp_ker_q.push_back(16'h0021);
        for (int i = 0; i < 3; i++) begin
            dut_ker_read_en = 1'b1;
            tick();
        end
        dut_ker_read_en = 1'b0;
        #1;
        chk("r3_ker_overrun_error", 32'(error), 32'd1);
        for (int i = 0; i < 11; i++) tick();
        #1;
        chk("r3_busy_before_timeout", 32'(busy), 32'd1);
        tick(); #1;
        chk("r3_timeout_busy", 32'(busy), 32'd0);
        chk("r3_timeout_error", 32'(error), 32'd1);
        chk("r3_timeout_not_done", 32'(done), 32'd0);

        // Run 4: start from ERR clears the error and re-reads the bases.
        launch_to_run("r4");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        chk("in_reads_left", 32'(exp_in_q.size()), 32'd0);
        chk("ker_reads_left", 32'(exp_ker_q.size()), 32'd0);
        chk("out_writes_left", 32'(exp_out_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
